// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a synchronous song ROM of 5-bit note codes,
// holds each note for one beat and drives the 11-bit speaker divider preset.
// Build option: define TONE_SEQ_LOOP_EN to restart the song from address 0
// after the end marker instead of returning to idle.
module tone_sequencer #(
  parameter int BEAT_DIV = 3000000,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_data,
  output logic [10:0]       tone,
  output logic [4:0]        note_code,
  output logic              playing,
  output logic              done
);

  localparam int                CNT_W    = $clog2(BEAT_DIV);
  localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BEAT_DIV - 1);
  localparam logic [10:0]       SILENCE  = 11'd2047;
  localparam logic [4:0]        END_CODE = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_END
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic [10:0]      tone_q;
  logic             beat_wrap;

  // Note code to divider preset; codes 0 and 22..31 are silent.
  function automatic logic [10:0] note_tone(input logic [4:0] code);
    logic [10:0] t;
    case (code)
      5'd1:  t = 11'd773;
      5'd2:  t = 11'd912;
      5'd3:  t = 11'd1036;
      5'd4:  t = 11'd1116;
      5'd5:  t = 11'd1197;
      5'd6:  t = 11'd1290;
      5'd7:  t = 11'd1372;
      5'd8:  t = 11'd1410;
      5'd9:  t = 11'd1480;
      5'd10: t = 11'd1542;
      5'd11: t = 11'd1576;
      5'd12: t = 11'd1622;
      5'd13: t = 11'd1668;
      5'd14: t = 11'd1728;
      5'd15: t = 11'd1763;
      5'd16: t = 11'd1794;
      5'd17: t = 11'd1808;
      5'd18: t = 11'd1836;
      5'd19: t = 11'd1858;
      5'd20: t = 11'd1877;
      5'd21: t = 11'd1900;
      default: t = SILENCE;
    endcase
    return t;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; stop overrides every transition, including start.
  always_comb begin
    state_nxt = state;
    beat_wrap = (beat_cnt == BEAT_LAST) && !pause;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = (rom_data == END_CODE) ? S_END : S_PLAY;
      S_PLAY:  if (beat_wrap) state_nxt = S_FETCH;
`ifdef TONE_SEQ_LOOP_EN
      S_END:   state_nxt = S_FETCH;
`else
      S_END:   state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
    if (stop) state_nxt = S_IDLE;
  end

  // Address, beat counter, held note and status flags.
  always_ff @(posedge clk) begin
    if (rst || stop) begin
      rom_addr  <= '0;
      beat_cnt  <= '0;
      tone_q    <= SILENCE;
      note_code <= '0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      playing <= (state_nxt != S_IDLE);
      case (state)
        S_LOAD: begin
          beat_cnt <= '0;
          if (rom_data == END_CODE) begin
            tone_q    <= SILENCE;
            note_code <= '0;
            rom_addr  <= '0;
            done      <= 1'b1;
          end else begin
            tone_q    <= note_tone(rom_data);
            note_code <= rom_data;
          end
        end
        S_PLAY: begin
          if (!pause) begin
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt <= '0;
              rom_addr <= rom_addr + 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_IDLE:  rom_addr <= '0;
        default: ;
      endcase
    end
  end

  // Pause silences the speaker immediately while the held note is kept.
  always_comb begin
    tone = tone_q;
    if (state == S_PLAY && pause) tone = SILENCE;
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Testbench for tone_sequencer: directed scenarios followed by random
// start/stop/pause/reset traffic, checked every cycle against a model of
// the song timing (fixed-length note slots, END slot, pause stretch).
module tb_tone_sequencer;

  localparam int BD = 4;
  localparam int AW = 2;
  localparam int NROM = 1 << AW;
  localparam int SLOT = BD + 2;

  logic          clk = 1'b0;
  logic          rst, start, stop, pause;
  logic [AW-1:0] rom_addr;
  logic [4:0]    rom_data;
  logic [10:0]   tone;
  logic [4:0]    note_code;
  logic          playing, done;

  logic [4:0] rom [NROM];

  int checks = 0;
  int errors = 0;

  // Model of the song position.
  int m_active, m_end, m_age, m_addr, m_held, m_code, m_done;
  int dut_done_cnt, mdl_done_cnt;

  int tone_tab [21] = '{773, 912, 1036, 1116, 1197, 1290, 1372,
                        1410, 1480, 1542, 1576, 1622, 1668, 1728,
                        1763, 1794, 1808, 1836, 1858, 1877, 1900};

  tone_sequencer #(.BEAT_DIV(BD), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .rom_addr(rom_addr), .rom_data(rom_data), .tone(tone),
    .note_code(note_code), .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM.
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic int code_tone(input int c);
    if (c >= 1 && c <= 21) return tone_tab[c-1];
    return 2047;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_end = 0; m_age = 0; m_addr = 0;
    m_held = 2047; m_code = 0; m_done = 0;
  endtask

  // Advance the model by one clock using the inputs present at that edge.
  task automatic model_step();
    int c;
    if (rst || stop) begin
      model_clear();
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (start) begin m_active = 1; m_age = 0; m_addr = 0; end
      end else if (m_end) begin
        m_end = 0;
        m_addr = 0;
`ifdef TONE_SEQ_LOOP_EN
        m_age = 0;
`else
        m_active = 0;
`endif
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (m_age == 1) begin
        c = rom[m_addr];
        if (c == 31) begin
          m_end = 1; m_done = 1; m_held = 2047; m_code = 0; m_addr = 0;
        end else begin
          m_held = code_tone(c); m_code = c; m_age = 2;
        end
      end else if (!pause) begin
        if (m_age == SLOT - 1) begin
          m_age = 0;
          m_addr = (m_addr + 1) % NROM;
        end else begin
          m_age++;
        end
      end
    end
  endtask

  task automatic step();
    int exp_tone;
    @(posedge clk);
    model_step();
    #1;
    exp_tone = (m_active && !m_end && m_age >= 2 && pause) ? 2047 : m_held;
    check("tone", int'(tone), exp_tone);
    check("rom_addr", int'(rom_addr), m_addr);
    check("note_code", int'(note_code), m_code);
    check("playing", int'(playing), m_active);
    check("done", int'(done), m_done);
    dut_done_cnt += int'(done);
    mdl_done_cnt += m_done;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1; step(); stop = 1'b0; step();
  endtask

  task automatic load_rom(input int a, input int b, input int c, input int d);
    rom[0] = 5'(a); rom[1] = 5'(b); rom[2] = 5'(c); rom[3] = 5'(d);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    model_clear();
    dut_done_cnt = 0; mdl_done_cnt = 0;
    load_rom(8, 9, 31, 0);
    run(3);
    rst = 1'b0;

    // Idle with no start: nothing moves.
    run(50);

    // Two notes then the end marker.
    dut_done_cnt = 0; mdl_done_cnt = 0;
    pulse_start();
    run(30);
    check("done_pulses_song", dut_done_cnt, mdl_done_cnt);
    halt();

    // Pause in the middle of a high note.
    load_rom(15, 31, 0, 0);
    pulse_start();
    run(3);
    pause = 1'b1; run(10);
    pause = 1'b0; run(20);
    halt();

    // Stop together with start on the second cycle of a note.
    load_rom(8, 9, 31, 0);
    pulse_start();
    run(3);
    stop = 1'b1; start = 1'b1; step();
    stop = 1'b0; start = 1'b0;
    run(10);

    // Song without end marker wraps the address.
    load_rom(0, 22, 7, 14);
    pulse_start();
    run(60);
    halt();

    // Single note plus end marker (repeats when looping is built in).
    dut_done_cnt = 0; mdl_done_cnt = 0;
    load_rom(1, 31, 0, 0);
    pulse_start();
    run(40);
    check("done_pulses_loop", dut_done_cnt, mdl_done_cnt);
    halt();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      start = 1'b0; stop = 1'b0; rst = 1'b0;
      if (!m_active && $urandom_range(0, 3) == 0) begin
        for (int k = 0; k < NROM; k++)
          rom[k] = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      end
      if ($urandom_range(0, 7) == 0) start = 1'b1;
      if ($urandom_range(0, 79) == 0) stop = 1'b1;
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if ($urandom_range(0, 5) == 0) pause = ~pause;
      step();
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0; pause = 1'b0;
    run(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
